// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter and access sequencer for a word-access data memory.
// Misaligned or out-of-range requests are answered with ack+err and never reach the memory.
module dmem_arbiter #(
  parameter int MEM_BYTES = 100,
  parameter int MEM_LAT   = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        busy,
  output logic [31:0] address,
  output logic [31:0] write_data,
  output logic        mem_r_en,
  output logic        mem_w_en,
  input  logic [31:0] data
);

  localparam int CW = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic          last_r;
  logic          owner_r;
  logic          we_r;
  logic [CW-1:0] cnt_r;

  logic          grant_s;
  logic          port_s;
  logic          legal_s;
  logic          sel_we_s;
  logic [31:0]   sel_addr_s;
  logic [31:0]   sel_wdata_s;

  // Arbitration in IDLE: a tie goes to the port that was not served last
  always_comb begin
    grant_s = 1'b0;
    port_s  = 1'b0;
    if (state_r == IDLE) begin
      if (req0 && req1) begin
        grant_s = 1'b1;
        port_s  = ~last_r;
      end else if (req0) begin
        grant_s = 1'b1;
        port_s  = 1'b0;
      end else if (req1) begin
        grant_s = 1'b1;
        port_s  = 1'b1;
      end else begin
        grant_s = 1'b0;
        port_s  = 1'b0;
      end
    end else begin
      grant_s = 1'b0;
      port_s  = 1'b0;
    end
    sel_we_s    = port_s ? we1    : we0;
    sel_addr_s  = port_s ? addr1  : addr0;
    sel_wdata_s = port_s ? wdata1 : wdata0;
    // 33-bit sum so addresses near 2^32 cannot wrap into the legal range
    legal_s = (sel_addr_s[1:0] == 2'b00) &&
              (({1'b0, sel_addr_s} + 33'd3) < 33'(MEM_BYTES));
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_s) begin
          state_s = legal_s ? ACCESS : RESP;
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS: state_s = WAIT;
      WAIT: begin
        if (cnt_r <= CW'(1)) begin
          state_s = RESP;
        end else begin
          state_s = WAIT;
        end
      end
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Registered datapath and outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      last_r     <= 1'b1;
      owner_r    <= 1'b0;
      we_r       <= 1'b0;
      cnt_r      <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      err0       <= 1'b0;
      err1       <= 1'b0;
      rdata0     <= 32'h0;
      rdata1     <= 32'h0;
      busy       <= 1'b0;
      address    <= 32'h0;
      write_data <= 32'h0;
      mem_r_en   <= 1'b0;
      mem_w_en   <= 1'b0;
    end else begin
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      err0     <= 1'b0;
      err1     <= 1'b0;
      mem_r_en <= 1'b0;
      mem_w_en <= 1'b0;
      busy     <= (state_s != IDLE);
      case (state_r)
        IDLE: begin
          if (grant_s) begin
            owner_r <= port_s;
            we_r    <= sel_we_s;
            last_r  <= port_s;
            if (legal_s) begin
              address    <= sel_addr_s;
              write_data <= sel_wdata_s;
              mem_r_en   <= ~sel_we_s;
              mem_w_en   <= sel_we_s;
            end else if (port_s) begin
              ack1 <= 1'b1;
              err1 <= 1'b1;
            end else begin
              ack0 <= 1'b1;
              err0 <= 1'b1;
            end
          end
        end
        ACCESS: begin
          cnt_r <= CW'(MEM_LAT);
        end
        WAIT: begin
          cnt_r <= cnt_r - CW'(1);
          if (cnt_r <= CW'(1)) begin
            if (owner_r) begin
              ack1 <= 1'b1;
              if (!we_r) begin
                rdata1 <= data;
              end
            end else begin
              ack0 <= 1'b1;
              if (!we_r) begin
                rdata0 <= data;
              end
            end
          end
        end
        RESP: begin
          cnt_r <= '0;
        end
        default: begin
          cnt_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: table-driven single-port accesses plus hand-written multi-cycle sequences
// against two arbiter instances (MEM_LAT=1 and MEM_LAT=3) with behavioural memories.
module tb_dmem_arbiter;

  logic clock;
  logic reset;
  logic mem_init;

  logic        req0_a, req1_a, we0_a, we1_a;
  logic [31:0] addr0_a, addr1_a, wdata0_a, wdata1_a;
  logic        ack0_a, ack1_a, err0_a, err1_a, busy_a, mem_r_en_a, mem_w_en_a;
  logic [31:0] rdata0_a, rdata1_a, address_a, write_data_a, data_a;

  logic        req0_b, req1_b, we0_b, we1_b;
  logic [31:0] addr0_b, addr1_b, wdata0_b, wdata1_b;
  logic        ack0_b, ack1_b, err0_b, err1_b, busy_b, mem_r_en_b, mem_w_en_b;
  logic [31:0] rdata0_b, rdata1_b, address_b, write_data_b, data_b;

  dmem_arbiter #(.MEM_BYTES(100), .MEM_LAT(1)) u_a (
    .clock(clock), .reset(reset),
    .req0(req0_a), .req1(req1_a), .we0(we0_a), .we1(we1_a),
    .addr0(addr0_a), .addr1(addr1_a), .wdata0(wdata0_a), .wdata1(wdata1_a),
    .ack0(ack0_a), .ack1(ack1_a), .err0(err0_a), .err1(err1_a),
    .rdata0(rdata0_a), .rdata1(rdata1_a), .busy(busy_a),
    .address(address_a), .write_data(write_data_a),
    .mem_r_en(mem_r_en_a), .mem_w_en(mem_w_en_a), .data(data_a)
  );

  dmem_arbiter #(.MEM_BYTES(100), .MEM_LAT(3)) u_b (
    .clock(clock), .reset(reset),
    .req0(req0_b), .req1(req1_b), .we0(we0_b), .we1(we1_b),
    .addr0(addr0_b), .addr1(addr1_b), .wdata0(wdata0_b), .wdata1(wdata1_b),
    .ack0(ack0_b), .ack1(ack1_b), .err0(err0_b), .err1(err1_b),
    .rdata0(rdata0_b), .rdata1(rdata1_b), .busy(busy_b),
    .address(address_b), .write_data(write_data_b),
    .mem_r_en(mem_r_en_b), .mem_w_en(mem_w_en_b), .data(data_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural memories: latency 1 and a 3-stage read pipeline; junk when no read is issued
  logic [31:0] mem_a [0:31];
  logic [31:0] mem_b [0:31];
  logic [31:0] pipe_b [0:2];
  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) begin
        mem_a[i] <= 32'h0;
        mem_b[i] <= 32'h1000_0000 + 32'(i);
      end
    end else begin
      if (mem_w_en_a) mem_a[address_a[6:2]] <= write_data_a;
      if (mem_w_en_b) mem_b[address_b[6:2]] <= write_data_b;
    end
    data_a    <= mem_r_en_a ? mem_a[address_a[6:2]] : 32'hBAD0_BAD0;
    pipe_b[0] <= mem_r_en_b ? mem_b[address_b[6:2]] : 32'hBAD0_BAD0;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign data_b = pipe_b[2];

  // Event monitor sampled on the falling edge
  int wcnt_a = 0, rcnt_a = 0, both_a = 0, ack0c_a = 0, ack1c_a = 0;
  int rcnt_b = 0, both_b = 0, ack0c_b = 0;
  logic [31:0] en_addr_a = 32'h0, en_wd_a = 32'h0, en_addr_b = 32'h0;
  always @(negedge clock) begin
    if (mem_w_en_a) begin wcnt_a++; en_addr_a = address_a; en_wd_a = write_data_a; end
    if (mem_r_en_a) begin rcnt_a++; en_addr_a = address_a; end
    if (mem_w_en_a && mem_r_en_a) both_a++;
    if (ack0_a) ack0c_a++;
    if (ack1_a) ack1c_a++;
    if (mem_r_en_b) begin rcnt_b++; en_addr_b = address_b; end
    if (mem_w_en_b && mem_r_en_b) both_b++;
    if (ack0_b) ack0c_b++;
  end

  int n_pass = 0, n_tot = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  typedef struct {
    logic        p;
    logic        w;
    logic [31:0] a;
    logic [31:0] wd;
    logic        e_err;
    logic [31:0] e_rd;
    int          lat;
  } vec_t;
  vec_t tv [12];

  // One access on the latency-1 instance; lat counts falling edges from request to ack
  task automatic run_acc(input vec_t v, input int k);
    int n, w0, r0, a0, a1;
    logic ak;
    w0 = wcnt_a; r0 = rcnt_a; a0 = ack0c_a; a1 = ack1c_a;
    if (v.p) begin req1_a = 1'b1; we1_a = v.w; addr1_a = v.a; wdata1_a = v.wd; end
    else     begin req0_a = 1'b1; we0_a = v.w; addr0_a = v.a; wdata0_a = v.wd; end
    n = 0; ak = 1'b0;
    while (!ak && n < 20) begin
      @(negedge clock);
      n++;
      ak = v.p ? ack1_a : ack0_a;
    end
    chk($sformatf("v%0d latency", k), 64'(n), 64'(v.lat));
    chk($sformatf("v%0d err", k), v.p ? err1_a : err0_a, v.e_err);
    chk($sformatf("v%0d rdata", k), v.p ? rdata1_a : rdata0_a, v.e_rd);
    req0_a = 1'b0; req1_a = 1'b0;
    @(negedge clock); #1;
    chk($sformatf("v%0d wen count", k), 64'(wcnt_a - w0), 64'(!v.e_err && v.w));
    chk($sformatf("v%0d ren count", k), 64'(rcnt_a - r0), 64'(!v.e_err && !v.w));
    chk($sformatf("v%0d ack0 count", k), 64'(ack0c_a - a0), 64'(!v.p));
    chk($sformatf("v%0d ack1 count", k), 64'(ack1c_a - a1), 64'(v.p));
    if (!v.e_err) chk($sformatf("v%0d mem address", k), en_addr_a, v.a);
    if (!v.e_err && v.w) chk($sformatf("v%0d mem wdata", k), en_wd_a, v.wd);
  endtask

  initial begin
    int n, m, a0, cnt;
    logic moved;
    int got_ord [6];
    int exp_ord [6];
    exp_ord = '{0, 1, 0, 1, 0, 1};

    tv[0]  = '{1'b0, 1'b1, 32'd8,         32'hDEAD_BEEF, 1'b0, 32'h0,         3};
    tv[1]  = '{1'b0, 1'b0, 32'd8,         32'h0,         1'b0, 32'hDEAD_BEEF, 3};
    tv[2]  = '{1'b1, 1'b1, 32'd96,        32'h1234_5678, 1'b0, 32'h0,         3};
    tv[3]  = '{1'b1, 1'b0, 32'd96,        32'h0,         1'b0, 32'h1234_5678, 3};
    tv[4]  = '{1'b0, 1'b0, 32'd6,         32'h0,         1'b1, 32'hDEAD_BEEF, 1};
    tv[5]  = '{1'b1, 1'b0, 32'd97,        32'h0,         1'b1, 32'h1234_5678, 1};
    tv[6]  = '{1'b0, 1'b0, 32'd100,       32'h0,         1'b1, 32'hDEAD_BEEF, 1};
    tv[7]  = '{1'b0, 1'b1, 32'd0,         32'hA5A5_0001, 1'b0, 32'hDEAD_BEEF, 3};
    tv[8]  = '{1'b0, 1'b0, 32'd0,         32'h0,         1'b0, 32'hA5A5_0001, 3};
    tv[9]  = '{1'b1, 1'b0, 32'd8,         32'h0,         1'b0, 32'hDEAD_BEEF, 3};
    tv[10] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 32'h5555_5555, 1'b1, 32'hA5A5_0001, 1};
    tv[11] = '{1'b1, 1'b1, 32'd98,        32'h6666_6666, 1'b1, 32'hDEAD_BEEF, 1};

    req0_a = 0; req1_a = 0; we0_a = 0; we1_a = 0;
    addr0_a = 0; addr1_a = 0; wdata0_a = 0; wdata1_a = 0;
    req0_b = 0; req1_b = 0; we0_b = 0; we1_b = 0;
    addr0_b = 0; addr1_b = 0; wdata0_b = 0; wdata1_b = 0;
    reset = 1'b1; mem_init = 1'b1;
    repeat (3) @(negedge clock);
    chk("reset ctl a", {ack0_a, ack1_a, err0_a, err1_a, busy_a, mem_r_en_a, mem_w_en_a}, 7'h0);
    chk("reset data a", {address_a, write_data_a}, 64'h0);
    chk("reset rdata a", {rdata0_a, rdata1_a}, 64'h0);
    reset = 1'b0; mem_init = 1'b0;

    for (int i = 0; i < 12; i++) run_acc(tv[i], i);

    // Reset mid-WAIT with a port-0 read in flight
    a0 = ack0c_a;
    req0_a = 1'b1; we0_a = 1'b0; addr0_a = 32'd8;
    @(negedge clock); @(negedge clock);
    chk("busy in wait", busy_a, 1'b1);
    reset = 1'b1; req0_a = 1'b0;
    @(negedge clock); @(negedge clock);
    chk("midrst ctl", {ack0_a, ack1_a, err0_a, err1_a, busy_a, mem_r_en_a, mem_w_en_a}, 7'h0);
    chk("midrst addr/wdata", {address_a, write_data_a}, 64'h0);
    chk("midrst rdata", {rdata0_a, rdata1_a}, 64'h0);
    reset = 1'b0;
    @(negedge clock); #1;
    chk("midrst no ack", 64'(ack0c_a - a0), 64'h0);

    // Simultaneous reads after reset: port 0 first, port 1 four cycles later
    req0_a = 1'b1; we0_a = 1'b0; addr0_a = 32'd96;
    req1_a = 1'b1; we1_a = 1'b0; addr1_a = 32'd0;
    n = 0;
    while (!ack0_a && n < 20) begin @(negedge clock); n++; end
    chk("sim ack0 latency", 64'(n), 64'd3);
    chk("sim ack1 not yet", ack1_a, 1'b0);
    chk("sim rdata0", rdata0_a, 32'h1234_5678);
    req0_a = 1'b0;
    m = 0; moved = 1'b0;
    while (!ack1_a && m < 20) begin
      @(negedge clock); m++;
      if (rdata0_a !== 32'h1234_5678 || ack0_a || err0_a) moved = 1'b1;
    end
    chk("sim ack1 gap", 64'(m), 64'd4);
    chk("sim rdata1", rdata1_a, 32'hA5A5_0001);
    chk("sim port0 quiet", moved, 1'b0);
    req1_a = 1'b0;
    @(negedge clock); #1;

    // Fairness: both held for six accesses
    req0_a = 1'b1; addr0_a = 32'd8;
    req1_a = 1'b1; addr1_a = 32'd96;
    n = 0; cnt = 0;
    while (cnt < 6 && n < 60) begin
      @(negedge clock); n++;
      if (ack0_a) begin got_ord[cnt] = 0; cnt++; end
      else if (ack1_a) begin got_ord[cnt] = 1; cnt++; end
    end
    req0_a = 1'b0; req1_a = 1'b0;
    chk("fair count", 64'(cnt), 64'd6);
    chk("fair cycles", 64'(n), 64'd23);
    for (int i = 0; i < 6; i++) chk($sformatf("fair order %0d", i), 64'(got_ord[i]), 64'(exp_ord[i]));
    chk("fair rdata0", rdata0_a, 32'hDEAD_BEEF);
    chk("fair rdata1", rdata1_a, 32'h1234_5678);
    @(negedge clock); #1;

    // MEM_LAT=3: address changes and req drops after grant
    a0 = ack0c_b; m = rcnt_b;
    req0_b = 1'b1; we0_b = 1'b0; addr0_b = 32'd12;
    n = 0;
    while (!ack0_b && n < 20) begin
      @(negedge clock); n++;
      if (n == 1) addr0_b = 32'd40;
      if (n == 2) req0_b = 1'b0;
      if (n == 3) chk("lat3 hold in wait", {mem_r_en_b, address_b}, {1'b0, 32'd12});
    end
    chk("lat3 ack latency", 64'(n), 64'd5);
    chk("lat3 rdata0", rdata0_b, 32'h1000_0003);
    chk("lat3 err0", err0_b, 1'b0);
    chk("lat3 mem address", en_addr_b, 32'd12);
    repeat (3) @(negedge clock);
    #1;
    chk("lat3 single ack", 64'(ack0c_b - a0), 64'd1);
    chk("lat3 single ren", 64'(rcnt_b - m), 64'd1);
    chk("lat3 port1 untouched", {ack1_b, err1_b, rdata1_b}, 34'h0);
    chk("lat3 idle", {busy_b, write_data_b}, 33'h0);

    chk("never both enables", 64'(both_a + both_b), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and access sequencer for the byte-addressed, word-access data memory. Port 0 is the pipeline MEM stage; port 1 is a secondary master (loader/debug/DMA). The block grants the single memory port round-robin, drives one read or write enable for exactly one cycle per access, waits the memory's read latency, and returns data with a one-cycle acknowledge. It also rejects misaligned or out-of-range word accesses without touching memory.

## Interface
- MEM_BYTES, 100: memory size in bytes; a word access is legal when addr+3 < MEM_BYTES.
- MEM_LAT, 1: cycles from the enable cycle until memory read data is valid (≥1).
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- req0, req1  in  1  access request; held high until the matching ack.
- we0, we1  in  1  1 = write, 0 = read; valid while req is high.
- addr0, addr1  in  32  byte address.
- wdata0, wdata1  in  32  write data.
- ack0, ack1  out  1  one-cycle completion pulse.
- err0, err1  out  1  pulses with ack when the access was rejected.
- rdata0, rdata1  out  32  read result; updated only on a successful read ack; otherwise holds.
- busy  out  1  high in any state other than IDLE.
- address  out  32  memory byte address.
- write_data  out  32  memory write data.
- mem_r_en, mem_w_en  out  1  memory read/write enables.
- data  in  32  memory read data.

## Operation
- All outputs are registered. Reset value of every output is 0. The round-robin pointer `last` resets to 1, so port 0 wins the first tie.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- **IDLE**
  - No req: stay in IDLE.
  - Exactly one req: grant that port.
  - Both req: grant the port ≠ `last`.
  - On grant: latch owner, we, addr, wdata; set `last` = owner.
  - Rejected access (addr[1:0] ≠ 0, or addr+3 ≥ MEM_BYTES): go to RESP with the error flag set. No enable is asserted.
  - Legal access: go to ACCESS.
- **ACCESS** (one cycle)
  - address = latched addr.
  - write_data = latched wdata.
  - Exactly one of mem_r_en / mem_w_en is high.
  - Load the wait counter with MEM_LAT; go to WAIT.
- **WAIT**
  - Enables low; address and write_data hold.
  - Decrement the counter each cycle.
  - On the edge ending the last WAIT cycle: for a read, capture data into rdata[owner]; go to RESP.
  - Writes also pass through WAIT, giving uniform timing.
- **RESP** (one cycle)
  - ack[owner] = 1; err[owner] = 1 if rejected.
  - Requests are not sampled in this cycle; go to IDLE.
- Latched fields are immune to requester changes after grant.
- A requester dropping req early does not abort the access: the access completes and ack still pulses.
- A req still high in the IDLE cycle after its ack is treated as a new request.
- The non-owner's rdata, ack and err never change during another port's access.
- address and write_data hold their last driven value while in IDLE.
- Reset mid-operation: the FSM returns to IDLE and all outputs clear. The in-flight access is abandoned with no ack. A write whose enable cycle already completed remains in memory.

## Timing
- Request sampled in IDLE at cycle t:
  - ACCESS at t+1 (enable high).
  - WAIT at t+2 … t+1+MEM_LAT.
  - RESP at t+2+MEM_LAT (ack high, rdata valid).
  - IDLE at t+3+MEM_LAT.
- Rejected access: RESP at t+1, IDLE at t+2.
- Back-to-back accesses from alternating ports: one per MEM_LAT+3 cycles.
- A port waits at most one other access before being granted.
- mem_r_en and mem_w_en are never both high. Each is high for exactly one cycle per legal access.

## Test plan
- **Reset:** assert reset for 2 cycles mid-WAIT → all outputs 0, busy 0, no ack; the next tie grants port 0.
- **Write then read, port 0, MEM_LAT=1:**
  - Write 0xDEADBEEF to addr 8 → mem_w_en high one cycle with address 8; ack0 at t+3; rdata0 unchanged.
  - Read addr 8 → ack0 at t+3, rdata0 = 0xDEADBEEF.
- **Simultaneous reads:** req0 and req1 rise together, both held → port 0 served first, port 1 granted in the IDLE cycle right after ack0; ack1 lands 4 cycles after ack0; rdata0 unchanged during port 1's access.
- **Fairness:** both ports request continuously for 6 accesses → grants alternate 0,1,0,1,0,1.
- **Rejections:**
  - addr 0x6 → ack+err at t+1, no enable asserted.
  - addr 97 with MEM_BYTES=100 → ack+err.
  - addr 96 → normal ack, err 0.
- **Latency and hold:** MEM_LAT=3; requester changes addr0 after grant → access uses the original address; ack at t+5; port 0 drops req before ack → ack0 still pulses once.
